// File: rtl/angle_reduce.sv
// Range reduction for the CORDIC cosine path: |a| mod 2*pi by restoring
// shift-subtract, then fold into [-pi/2, pi/2] with a negate flag.
module angle_reduce #(
  parameter int IN_W    = 32,
  parameter int FRAC    = 18,
  parameter int ITER    = 11,
  parameter int TWO_PI  = 1647099,
  parameter int PI      = 823550,
  parameter int HALF_PI = 411775
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic signed [IN_W-1:0] a,
  output logic signed [21:0]     z,
  output logic                   neg,
  output logic                   busy,
  output logic                   done
);

  localparam int ZW = 22;
  localparam int CW = IN_W + ITER;
  localparam int KW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [CW-1:0]   TP_C = CW'(TWO_PI);
  localparam logic [IN_W-1:0] HP_M = IN_W'(HALF_PI);
  localparam logic [IN_W-1:0] P3_M = IN_W'(PI + HALF_PI);
  localparam logic [ZW-1:0]   PI_Z = ZW'(PI);
  localparam logic [ZW-1:0]   TP_Z = ZW'(TWO_PI);
  localparam logic [KW-1:0]   K_HI = KW'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE,
    ITERATE,
    FOLD
  } state_t;

  state_t          state_q, state_d;
  logic [IN_W-1:0] m_q, m_d;
  logic [KW-1:0]   k_q, k_d;
  logic [ZW-1:0]   z_q, z_d;
  logic            neg_q, neg_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [CW-1:0]   m_ext;
  logic [CW-1:0]   tp_sh;
  logic            ge;
  logic [IN_W-1:0] a_abs;
  logic [ZW-1:0]   r_z;

  assign m_ext = CW'(m_q);
  assign tp_sh = TP_C << k_q;
  assign ge    = (m_ext >= tp_sh);
  // -(-2^(IN_W-1)) wraps to 2^(IN_W-1), which is the exact unsigned magnitude
  assign a_abs = a[IN_W-1] ? IN_W'(-a) : IN_W'(a);
  assign r_z   = m_q[ZW-1:0];

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    k_d     = k_q;
    z_d     = z_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a_abs;
          k_d     = K_HI;
          busy_d  = 1'b1;
          state_d = ITERATE;
        end
      end
      ITERATE: begin
        // tp_sh never exceeds m here when ge, so the low IN_W bits suffice
        if (ge) begin
          m_d = m_q - tp_sh[IN_W-1:0];
        end
        if (k_q == '0) begin
          busy_d  = 1'b0;
          state_d = FOLD;
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      FOLD: begin
        if (m_q <= HP_M) begin
          z_d   = r_z;
          neg_d = 1'b0;
        end else if (m_q <= P3_M) begin
          z_d   = r_z - PI_Z;
          neg_d = 1'b1;
        end else begin
          z_d   = r_z - TP_Z;
          neg_d = 1'b0;
        end
        done_d  = 1'b1;
        m_d     = '0;
        k_d     = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      k_q     <= '0;
      z_q     <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      k_q     <= k_d;
      z_q     <= z_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign z    = z_q;
  assign neg  = neg_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_angle_reduce.sv
// Bench for angle_reduce: directed corners plus random angles checked
// against an arithmetic model of mod-2pi reduction and quadrant folding.
module tb_angle_reduce;

  localparam longint TWO_PI  = 1647099;
  localparam longint PI      = 823550;
  localparam longint HALF_PI = 411775;

  logic               clk;
  logic               reset;
  logic               start;
  logic signed [31:0] a_i;
  logic signed [21:0] z_o;
  logic               neg_o;
  logic               busy_o;
  logic               done_o;

  int n_chk;
  int n_err;

  angle_reduce dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a_i),
    .z     (z_o),
    .neg   (neg_o),
    .busy  (busy_o),
    .done  (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic signed [31:0] av,
                                output longint ez, output longint en);
    longint m;
    longint r;
    m = (av < 0) ? -longint'(av) : longint'(av);
    r = m % TWO_PI;
    if (r <= HALF_PI) begin
      ez = r; en = 0;
    end else if (r <= PI + HALF_PI) begin
      ez = r - PI; en = 1;
    end else begin
      ez = r - TWO_PI; en = 0;
    end
  endfunction

  // Called at a negedge; leaves the bench at the negedge where done is seen.
  task automatic run_op(input logic signed [31:0] av, input int inj_at);
    longint ez, en;
    int j, nb;
    model(av, ez, en);
    a_i   = av;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_i   = $urandom;
    j  = 0;
    nb = 0;
    while (!done_o && j < 40) begin
      if (busy_o) nb++;
      if (j == inj_at) begin
        start = 1'b1;
        a_i   = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      j++;
    end
    start = 1'b0;
    chk("done_seen", longint'(done_o), 1);
    chk("latency", j, 12);
    chk("busy_cycles", nb, 11);
    chk("z", longint'(z_o), ez);
    chk("neg", longint'(neg_o), en);
  endtask

  task automatic idle_check(input string tag, input int cycles);
    int nd;
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done_o) nd++;
    end
    chk(tag, nd, 0);
  endtask

  initial begin
    logic signed [31:0] r;
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    a_i   = '0;
    repeat (2) @(negedge clk);
    chk("rst_z", longint'(z_o), 0);
    chk("rst_neg", longint'(neg_o), 0);
    chk("rst_busy", longint'(busy_o), 0);
    chk("rst_done", longint'(done_o), 0);
    reset = 1'b0;
    @(negedge clk);

    // Chained: each start lands in the done cycle of the previous op.
    run_op(32'sd0, -1);
    run_op(32'sd823550, -1);
    run_op(-32'sd262144, -1);
    run_op(32'sd1048576, -1);
    run_op(32'sd262144000, -1);
    run_op(32'sh8000_0000, -1);
    chk("corner_z", longint'(z_o), -333448);
    @(negedge clk);
    chk("done_pulse_low", longint'(done_o), 0);

    // start while busy must not disturb the op in flight
    run_op(32'sd262144000, 4);
    idle_check("single_done", 15);

    // Reset during iteration 5 aborts cleanly
    run_op(32'sd1048576, -1);
    a_i   = 32'sd823550;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_z", longint'(z_o), 0);
    chk("abort_neg", longint'(neg_o), 0);
    chk("abort_busy", longint'(busy_o), 0);
    chk("abort_done", longint'(done_o), 0);
    @(negedge clk);
    reset = 1'b0;
    idle_check("abort_no_done", 20);

    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        r = $urandom;
      end else begin
        r = $signed(32'($urandom_range(0, 4000000)));
        if ($urandom_range(0, 1) == 1) r = -r;
      end
      run_op(r, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/angle_reduce.md
Name: angle_reduce

Overview:
- Upstream range-reduction stage for the CORDIC cosine path; sits between float-to-fixed conversion and the CORDIC core.
- Takes a wide signed fixed-point angle, reduces it modulo 2π with an iterative restoring shift-subtract, then folds the result into [-π/2, π/2], the CORDIC convergence range.
- Emits the 22-bit reduced angle, a result-negate flag (cos(x) = -cos(z) when set) and a one-cycle done pulse that drives the CORDIC start input.

Parameters:
- IN_W, 32, input angle width, signed two's complement.
- FRAC, 18, fraction bits of both input and output. Output is Q3.18 in 22 bits.
- ITER, 11, number of restoring iterations. Requires 2π·2^ITER > 2^(IN_W-1).
- TWO_PI, 1647099, round(2π·2^FRAC).
- PI, 823550, round(π·2^FRAC).
- HALF_PI, 411775, round(π/2·2^FRAC).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request; samples a.
- a  input  IN_W  signed fixed-point angle in radians, FRAC fraction bits.
- z  output  22  signed Q3.18 reduced angle, in [-π/2, π/2].
- neg  output  1  set when the cosine result must be negated.
- busy  output  1  high while a reduction is in progress.
- done  output  1  one-cycle pulse; z/neg are valid from this cycle on.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - z=0, neg=0, busy=0, done=0, FSM to IDLE, work registers cleared.
  - No done is produced for an aborted operation.
- FSM states: IDLE, ITERATE, FOLD.
- IDLE:
  - On start=1, register M = |a| as an unsigned IN_W-bit value. |−2^(IN_W-1)| = 2^(IN_W-1) exactly; no overflow.
  - Set k = ITER-1, busy=1, go to ITERATE.
- ITERATE, one step per cycle:
  - If M ≥ (TWO_PI << k), then M ← M − (TWO_PI << k).
  - Compare and subtract at IN_W+ITER bits; no truncation.
  - When k=0, go to FOLD; otherwise decrement k.
  - Exit invariant: 0 ≤ M < TWO_PI.
- FOLD, one cycle, r = M:
  - r ≤ HALF_PI: z=r, neg=0.
  - HALF_PI < r ≤ PI+HALF_PI: z=r−PI, neg=1.
  - r > PI+HALF_PI: z=r−TWO_PI, neg=0.
  - Register z and neg, pulse done=1, clear busy, return to IDLE.
- Sign handling: the input sign is discarded because cos is even.
- Latency: start sampled at edge n; done is high in the cycle after edge n+ITER+1, i.e. ITER+1 cycles after start (12 at default). Fixed and data-independent.
- Output holding: z and neg hold their last value until the next FOLD. done is low at all other times.
- start while busy=1: ignored, with no effect on the operation in flight.
- start in the same cycle that done is high: accepted, because the FSM is already back in IDLE. Back-to-back throughput is one result per ITER+1 cycles.
- a is sampled only in the start cycle and may change freely afterwards.

Test Plan:
- Reset then start, a=0 → done after 12 cycles; z=0, neg=0; busy high for exactly 11 cycles.
- a=823550 (π) → z=0, neg=1.
- a=-262144 (-1.0) → z=262144, neg=0. Confirms the sign is dropped.
- a=1048576 (4.0) → z=225026, neg=1.
- Large inputs:
  - a=262144000 (1000.0) → z=255259, neg=0.
  - a=-2^31 → z=-333448, neg=0. Checks the magnitude corner and the third fold region.
- Protocol corners:
  - start pulsed mid-operation → ignored; the result matches the first request and exactly one done is produced.
  - reset asserted at iteration 5 → outputs 0 immediately, no done follows.
  - A new start coincident with done → second result arrives 12 cycles later.
